// File: rtl/turfio_delay_ctrl.sv
// IDELAY/ODELAY sequencer for one turfio_bit lane: tap write, readback and
// error-counting tap scans, with EN_VTC dropped around every load.
module turfio_delay_ctrl #(
    parameter int VTC_WAIT      = 10,
    parameter int SETTLE_CYCLES = 16,
    parameter int ERRW          = 16
) (
    input  logic            if_clk_i,
    input  logic            rst_n_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [1:0]      cmd_op_i,
    input  logic [1:0]      cmd_sel_i,
    input  logic [8:0]      cmd_value_i,
    input  logic [8:0]      scan_stop_i,
    input  logic [3:0]      scan_step_i,
    input  logic [15:0]     scan_len_i,
    input  logic [3:0]      train_pattern_i,
    input  logic [3:0]      data_i,
    output logic            delay_load_o,
    output logic            delay_rd_o,
    output logic [1:0]      delay_sel_o,
    output logic [8:0]      delay_cntvaluein_o,
    input  logic [8:0]      delay_cntvalueout_i,
    output logic            en_vtc_o,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [8:0]      rsp_value_o,
    output logic [ERRW-1:0] rsp_errors_o,
    output logic            rsp_last_o,
    output logic            busy_o
);

    // state   | meaning
    // IDLE    | waiting for a command, cmd_ready_o high
    // VTC_OFF | en_vtc low, counting down VTC_WAIT before the first load
    // LOAD    | one-cycle load pulse with the current tap
    // SETTLE  | counting down SETTLE_CYCLES after a scan load
    // MEASURE | counting data_i/train_pattern mismatches for scan_len cycles
    // RD      | one-cycle readback pulse
    // RD_WAIT | capturing the lane's registered readback
    // RESP    | presenting one response beat until accepted
    // VTC_ON  | en_vtc back high for one cycle before IDLE
    typedef enum logic [3:0] {
        IDLE, VTC_OFF, LOAD, SETTLE, MEASURE, RD, RD_WAIT, RESP, VTC_ON
    } state_t;

    localparam logic [1:0] OP_READ = 2'd1;
    localparam logic [1:0] OP_SCAN = 2'd2;
    localparam int CNTW = 16;
    localparam logic [CNTW-1:0] VTC_INIT    = CNTW'((VTC_WAIT > 1) ? VTC_WAIT - 1 : 0);
    localparam logic [CNTW-1:0] SETTLE_INIT = CNTW'((SETTLE_CYCLES > 1) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [ERRW-1:0] ERR_MAX     = {ERRW{1'b1}};

    state_t            state_q, state_d;
    logic [1:0]        op_q;
    logic [1:0]        sel_q;
    logic [8:0]        tap_q;
    logic [8:0]        stop_q;
    logic [3:0]        step_q;
    logic [15:0]       len_q;
    logic [3:0]        pat_q;
    logic [CNTW-1:0]   cnt_q;
    logic [ERRW-1:0]   err_q;
    logic [8:0]        value_q;
    logic              last_q;
    logic              vtc_cmd_q;

    logic              reject_in;
    logic [9:0]        next_tap;
    logic              pt_last;

    assign reject_in = (cmd_op_i == 2'd3) || ((cmd_op_i != OP_READ) && cmd_sel_i[1]);
    // 10-bit sum so a step past tap 511 still terminates the scan
    assign next_tap  = {1'b0, tap_q} + {6'b0, step_q};
    assign pt_last   = next_tap > {1'b0, stop_q};

    always_ff @(posedge if_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    if (reject_in)               state_d = RESP;
                    else if (cmd_op_i == OP_READ) state_d = RD;
                    else                          state_d = VTC_OFF;
                end
            end
            VTC_OFF: if (cnt_q == '0) state_d = LOAD;
            LOAD:    state_d = (op_q == OP_SCAN) ? SETTLE : RD;
            SETTLE:  if (cnt_q == '0) state_d = MEASURE;
            MEASURE: if (cnt_q == '0) state_d = RESP;
            RD:      state_d = RD_WAIT;
            RD_WAIT: state_d = RESP;
            RESP: begin
                if (rsp_ready_i) begin
                    if (!last_q)        state_d = LOAD;
                    else if (vtc_cmd_q) state_d = VTC_ON;
                    else                state_d = IDLE;
                end
            end
            VTC_ON:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge if_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q      <= '0;
            sel_q     <= '0;
            tap_q     <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            len_q     <= '0;
            pat_q     <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            value_q   <= '0;
            last_q    <= 1'b0;
            vtc_cmd_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_q      <= cmd_op_i;
                        sel_q     <= cmd_sel_i;
                        tap_q     <= cmd_value_i;
                        stop_q    <= scan_stop_i;
                        step_q    <= (scan_step_i == 4'd0) ? 4'd1 : scan_step_i;
                        len_q     <= (scan_len_i == 16'd0) ? 16'd1 : scan_len_i;
                        pat_q     <= train_pattern_i;
                        cnt_q     <= VTC_INIT;
                        err_q     <= reject_in ? ERR_MAX : '0;
                        value_q   <= '0;
                        last_q    <= reject_in || (cmd_op_i != OP_SCAN);
                        vtc_cmd_q <= !reject_in && (cmd_op_i != OP_READ);
                    end
                end
                VTC_OFF: if (cnt_q != '0) cnt_q <= cnt_q - CNTW'(1);
                LOAD: begin
                    err_q   <= '0;
                    value_q <= tap_q;
                    cnt_q   <= SETTLE_INIT;
                    if (op_q == OP_SCAN) last_q <= pt_last;
                end
                SETTLE: begin
                    if (cnt_q == '0) cnt_q <= len_q - 16'd1;
                    else             cnt_q <= cnt_q - CNTW'(1);
                end
                MEASURE: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CNTW'(1);
                    if ((data_i != pat_q) && (err_q != ERR_MAX)) err_q <= err_q + ERRW'(1);
                end
                RD_WAIT: value_q <= delay_cntvalueout_i;
                RESP: if (rsp_ready_i && !last_q) tap_q <= next_tap[8:0];
                default: ;
            endcase
        end
    end

    assign cmd_ready_o        = (state_q == IDLE);
    assign busy_o             = (state_q != IDLE);
    assign delay_load_o       = (state_q == LOAD);
    assign delay_rd_o         = (state_q == RD);
    assign delay_sel_o        = (state_q == IDLE) ? 2'd0 : sel_q;
    assign delay_cntvaluein_o = tap_q;
    assign en_vtc_o           = !(vtc_cmd_q && (state_q != IDLE) && (state_q != VTC_ON));
    assign rsp_valid_o        = (state_q == RESP);
    assign rsp_value_o        = value_q;
    assign rsp_errors_o       = err_q;
    assign rsp_last_o         = last_q;

endmodule

// File: tb/tb_turfio_delay_ctrl.sv
// Scoreboard bench for turfio_delay_ctrl: a lane model answers loads/reads,
// expected beats are queued at issue time and checked by a separate monitor.
module tb_turfio_delay_ctrl;

    localparam int VW   = 10;
    localparam int SC   = 16;
    localparam int EW   = 8;
    localparam int EMAX = (1 << EW) - 1;

    logic          if_clk_i;
    logic          rst_n_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [1:0]    cmd_sel_i;
    logic [8:0]    cmd_value_i;
    logic [8:0]    scan_stop_i;
    logic [3:0]    scan_step_i;
    logic [15:0]   scan_len_i;
    logic [3:0]    train_pattern_i;
    logic [3:0]    data_i;
    logic          delay_load_o;
    logic          delay_rd_o;
    logic [1:0]    delay_sel_o;
    logic [8:0]    delay_cntvaluein_o;
    logic [8:0]    delay_cntvalueout_i;
    logic          en_vtc_o;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [8:0]    rsp_value_o;
    logic [EW-1:0] rsp_errors_o;
    logic          rsp_last_o;
    logic          busy_o;

    turfio_delay_ctrl #(.VTC_WAIT(VW), .SETTLE_CYCLES(SC), .ERRW(EW)) dut (
        .if_clk_i(if_clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_sel_i(cmd_sel_i), .cmd_value_i(cmd_value_i),
        .scan_stop_i(scan_stop_i), .scan_step_i(scan_step_i), .scan_len_i(scan_len_i),
        .train_pattern_i(train_pattern_i), .data_i(data_i),
        .delay_load_o(delay_load_o), .delay_rd_o(delay_rd_o), .delay_sel_o(delay_sel_o),
        .delay_cntvaluein_o(delay_cntvaluein_o), .delay_cntvalueout_i(delay_cntvalueout_i),
        .en_vtc_o(en_vtc_o), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_value_o(rsp_value_o), .rsp_errors_o(rsp_errors_o), .rsp_last_o(rsp_last_o),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic [8:0]    v;
        logic [EW-1:0] e;
        logic          l;
    } beat_t;

    beat_t      exp_q[$];
    int         n_chk  = 0;
    int         n_fail = 0;
    int         ready_mode = 0;
    bit         scan_active = 0;
    bit         all_wrong = 0;
    int         cur_len = 1;
    int         k_tab[int];
    logic [8:0] lane_tap [4] = '{9'h013, 9'h1C7, 9'h0A5, 9'h15A};
    logic [8:0] exp_tap  [4] = '{9'h013, 9'h1C7, 9'h0A5, 9'h15A};

    initial begin
        if_clk_i = 0;
        forever #5 if_clk_i = ~if_clk_i;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // lane: taps survive controller reset; readback registered on the rd cycle
    always @(posedge if_clk_i) begin
        if (delay_load_o) lane_tap[delay_sel_o] <= delay_cntvaluein_o;
        if (delay_rd_o) delay_cntvalueout_i <= lane_tap[delay_sel_o];
    end

    initial begin
        rsp_ready_i = 1;
        forever begin
            @(posedge if_clk_i);
            #1;
            case (ready_mode)
                0: rsp_ready_i = 1'b1;
                1: rsp_ready_i = ($urandom_range(0, 2) != 0);
                default: rsp_ready_i = 1'b0;
            endcase
        end
    end

    // training data: junk outside the measure window, k wrong words at its start
    initial begin
        int tap, k;
        data_i = 0;
        forever begin
            @(negedge if_clk_i);
            data_i = 4'($urandom);
            if (rst_n_i && scan_active && delay_load_o) begin
                tap = int'(delay_cntvaluein_o);
                k = all_wrong ? cur_len : (k_tab.exists(tap) ? k_tab[tap] : 0);
                repeat (SC) begin
                    @(negedge if_clk_i);
                    data_i = 4'($urandom);
                end
                for (int j = 1; j <= cur_len; j++) begin
                    @(negedge if_clk_i);
                    data_i = (j <= k) ? (train_pattern_i ^ 4'($urandom_range(1, 15)))
                                      : train_pattern_i;
                end
            end
        end
    end

    initial begin
        beat_t got, want, prev;
        bit    stall_prev = 0;
        forever begin
            @(negedge if_clk_i);
            if (!rst_n_i || !rsp_valid_o) begin
                stall_prev = 0;
            end else begin
                got = '{rsp_value_o, rsp_errors_o, rsp_last_o};
                if (stall_prev) chk("rsp_stable_under_backpressure", 32'(got), 32'(prev));
                if (rsp_ready_i) begin
                    stall_prev = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1, 0);
                    end else begin
                        want = exp_q.pop_front();
                        chk("rsp_value", 32'(got.v), 32'(want.v));
                        chk("rsp_errors", 32'(got.e), 32'(want.e));
                        chk("rsp_last", 32'(got.l), 32'(want.l));
                    end
                end else begin
                    stall_prev = 1;
                    prev = got;
                end
            end
        end
    end

    function automatic void push_beat(input int v, input int e, input bit l);
        exp_q.push_back('{9'(v), EW'(e), l});
    endfunction

    // mode 0: use k_tab as set, 1: every cycle wrong, 2: random k per tap
    function automatic void push_scan(input int sel, input int start, input int stop,
                                      input int step, input int len_eff, input int mode);
        int st = (step == 0) ? 1 : step;
        int t = start;
        int k;
        bit last;
        if (mode == 2) k_tab.delete();
        all_wrong = (mode == 1);
        cur_len = len_eff;
        forever begin
            last = (t + st) > stop;
            if (mode == 2) k_tab[t] = $urandom_range(0, len_eff);
            k = (mode == 1) ? len_eff : (k_tab.exists(t) ? k_tab[t] : 0);
            push_beat(t, (k > EMAX) ? EMAX : k, last);
            if (last) break;
            t += st;
        end
        exp_tap[sel] = 9'(t);
    endfunction

    task automatic issue(input logic [1:0] op, input logic [1:0] sel, input logic [8:0] val,
                         input logic [8:0] stop, input logic [3:0] step, input logic [15:0] len);
        int n = 0;
        @(negedge if_clk_i);
        while (!cmd_ready_o && n < 50000) begin
            @(negedge if_clk_i);
            n++;
        end
        chk("cmd_ready_before_issue", 32'(cmd_ready_o), 1);
        cmd_op_i    = op;
        cmd_sel_i   = sel;
        cmd_value_i = val;
        scan_stop_i = stop;
        scan_step_i = step;
        scan_len_i  = len;
        cmd_valid_i = 1;
        @(posedge if_clk_i);
        #1;
        cmd_valid_i = 0;
        cmd_op_i    = 2'($urandom);
        cmd_sel_i   = 2'($urandom);
        cmd_value_i = 9'($urandom);
        scan_stop_i = 9'($urandom);
        scan_step_i = 4'($urandom);
        scan_len_i  = 16'($urandom);
    endtask

    task automatic wait_hs();
        int n = 0;
        while (!(rsp_valid_o && rsp_ready_i) && n < 2000) begin
            @(negedge if_clk_i);
            n++;
        end
        chk("handshake_seen", 32'(rsp_valid_o && rsp_ready_i), 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40000) begin
            @(negedge if_clk_i);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int cnt, bad, n;
        rst_n_i = 0;
        cmd_valid_i = 0;
        cmd_op_i = 0; cmd_sel_i = 0; cmd_value_i = 0;
        scan_stop_i = 0; scan_step_i = 0; scan_len_i = 0;
        train_pattern_i = 4'h9;
        repeat (3) @(negedge if_clk_i);
        chk("reset_handshake_flags", {cmd_ready_o, en_vtc_o, busy_o, rsp_valid_o}, 4'b1100);
        chk("reset_lane_pulses", {delay_load_o, delay_rd_o, delay_sel_o, delay_cntvaluein_o}, 0);
        chk("reset_rsp_fields", {rsp_value_o, rsp_errors_o, rsp_last_o}, 0);
        rst_n_i = 1;

        // read of IDELAY monitor, no backpressure
        push_beat(9'h0A5, 0, 1);
        issue(2'd1, 2'd2, 9'h000, 9'h0, 4'h0, 16'h0);
        @(negedge if_clk_i);
        chk("read_rd_pulse_t1", {delay_rd_o, delay_sel_o, en_vtc_o}, {1'b1, 2'd2, 1'b1});
        @(negedge if_clk_i);
        chk("read_rd_single", {delay_rd_o, en_vtc_o}, 2'b01);
        @(negedge if_clk_i);
        chk("read_rsp_t3", {rsp_valid_o, en_vtc_o}, 2'b11);
        wait_drain();

        // write ODELAY 0x123
        push_beat(9'h123, 0, 1);
        exp_tap[1] = 9'h123;
        issue(2'd0, 2'd1, 9'h123, 9'h0, 4'h0, 16'h0);
        cnt = 0;
        repeat (VW) begin
            @(negedge if_clk_i);
            if (!en_vtc_o && !delay_load_o) cnt++;
        end
        chk("write_vtc_low_cycles", cnt, VW);
        @(negedge if_clk_i);
        chk("write_load", {delay_load_o, delay_cntvaluein_o, delay_sel_o, en_vtc_o},
            {1'b1, 9'h123, 2'd1, 1'b0});
        @(negedge if_clk_i);
        chk("write_rd_l1", {delay_rd_o, delay_load_o}, 2'b10);
        @(negedge if_clk_i);
        @(negedge if_clk_i);
        chk("write_rsp_l3", 32'(rsp_valid_o), 1);
        wait_hs();
        chk("write_vtc_low_at_hs", 32'(en_vtc_o), 0);
        @(negedge if_clk_i);
        chk("write_vtc_on", {en_vtc_o, cmd_ready_o}, 2'b10);
        @(negedge if_clk_i);
        chk("write_back_idle", {en_vtc_o, cmd_ready_o, busy_o}, 3'b110);
        wait_drain();
        push_beat(9'h123, 0, 1);
        issue(2'd1, 2'd1, 9'h0, 9'h0, 4'h0, 16'h0);
        wait_drain();

        // scan 0..8 step 4, 3 errors at tap 4 only
        train_pattern_i = 4'h6;
        k_tab.delete();
        k_tab[4] = 3;
        push_scan(0, 0, 8, 4, 8, 0);
        scan_active = 1;
        issue(2'd2, 2'd0, 9'd0, 9'd8, 4'd4, 16'd8);
        wait_drain();
        scan_active = 0;

        // overflow scan with saturated error count, random backpressure
        ready_mode = 1;
        train_pattern_i = 4'hC;
        push_scan(1, 9'h1F0, 9'h1FF, 0, 300, 1);
        scan_active = 1;
        issue(2'd2, 2'd1, 9'h1F0, 9'h1FF, 4'd0, 16'd300);
        wait_drain();
        scan_active = 0;
        all_wrong = 0;

        // rejects, first held under backpressure
        ready_mode = 2;
        push_beat(0, EMAX, 1);
        issue(2'd3, 2'd0, 9'h055, 9'h0, 4'h0, 16'h0);
        bad = 0;
        repeat (22) begin
            @(negedge if_clk_i);
            if (delay_load_o || delay_rd_o || !en_vtc_o) bad++;
        end
        chk("reject_no_lane_activity", bad, 0);
        chk("reject_held_valid", 32'(rsp_valid_o), 1);
        ready_mode = 0;
        wait_drain();
        push_beat(0, EMAX, 1);
        issue(2'd0, 2'd3, 9'h1AA, 9'h0, 4'h0, 16'h0);
        bad = 0;
        repeat (4) begin
            @(negedge if_clk_i);
            if (delay_load_o || delay_rd_o || !en_vtc_o) bad++;
        end
        chk("reject_sel3_no_lane_activity", bad, 0);
        wait_drain();

        // randomized mix
        ready_mode = 1;
        for (int i = 0; i < 16; i++) begin
            int kind, sel, start, stop, step, len, le;
            kind  = $urandom_range(0, 4);
            sel   = $urandom_range(0, 1);
            start = $urandom_range(0, 511);
            step  = $urandom_range(0, 15);
            len   = $urandom_range(0, 12);
            le    = (len == 0) ? 1 : len;
            train_pattern_i = 4'($urandom);
            case (kind)
                0: begin
                    sel = $urandom_range(0, 3);
                    push_beat(exp_tap[sel], 0, 1);
                    issue(2'd1, 2'(sel), 9'($urandom), 9'h0, 4'h0, 16'h0);
                end
                1: begin
                    push_beat(start, 0, 1);
                    exp_tap[sel] = 9'(start);
                    issue(2'd0, 2'(sel), 9'(start), 9'h0, 4'h0, 16'h0);
                end
                2, 3: begin
                    if (start > 0 && $urandom_range(0, 4) == 0) stop = start - 1;
                    else stop = (start + $urandom_range(0, 40) > 511) ? 511
                                                                       : start + $urandom_range(0, 40);
                    push_scan(sel, start, stop, step, le, 2);
                    scan_active = 1;
                    issue(2'd2, 2'(sel), 9'(start), 9'(stop), 4'(step), 16'(len));
                end
                default: begin
                    push_beat(0, EMAX, 1);
                    if ($urandom_range(0, 1) == 0)
                        issue(2'd3, 2'($urandom), 9'(start), 9'h0, 4'h0, 16'h0);
                    else
                        issue(2'($urandom_range(0, 1) * 2), 2'($urandom_range(2, 3)),
                              9'(start), 9'h0, 4'h0, 16'h0);
                end
            endcase
            wait_drain();
            scan_active = 0;
        end

        // reset during MEASURE abandons the scan
        ready_mode = 0;
        train_pattern_i = 4'h3;
        k_tab.delete();
        all_wrong = 0;
        cur_len = 100;
        scan_active = 1;
        issue(2'd2, 2'd0, 9'd5, 9'd50, 4'd5, 16'd100);
        n = 0;
        while (!delay_load_o && n < 100) begin
            @(negedge if_clk_i);
            n++;
        end
        chk("reset_scan_load_seen", 32'(delay_load_o), 1);
        repeat (SC + 5) @(negedge if_clk_i);
        chk("pre_reset_measuring", {busy_o, en_vtc_o, rsp_valid_o}, 3'b100);
        rst_n_i = 0;
        #1;
        chk("reset_mid_scan_outputs", {en_vtc_o, rsp_valid_o, cmd_ready_o, busy_o}, 4'b1010);
        repeat (3) @(negedge if_clk_i);
        rst_n_i = 1;
        scan_active = 0;
        @(negedge if_clk_i);
        chk("after_reset_ready", 32'(cmd_ready_o), 1);
        push_beat(exp_tap[2], 0, 1);
        issue(2'd1, 2'd2, 9'h0, 9'h0, 4'h0, 16'h0);
        wait_drain();
        repeat (5) @(negedge if_clk_i);
        chk("no_leftover_expected", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
